// File: rtl/cpu_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpu_wb_arbiter_if
// Bundles the writeback-side signals of cpu_wb_arbiter.
//   alu_*  : single-cycle ALU result request (valid/ready, rd, data)
//   ld_*   : load result returning from data memory (valid/ready, rd, data)
//   iss_*  : decode issue notification used to set load scoreboard bits
//   q_a*   : scoreboard query addresses, busy* : query results
//   wen3/a3/wd3 : register bank write port
// master = producer/consumer side (decode, ALU, memory), slave = arbiter.
// ----------------------------------------------------------------------------
interface cpu_wb_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  alu_valid;
   logic                  alu_ready;
   logic [ADDR_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0] alu_data;
   logic                  ld_valid;
   logic                  ld_ready;
   logic [ADDR_WIDTH-1:0] ld_rd;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  iss_valid;
   logic                  iss_is_load;
   logic [ADDR_WIDTH-1:0] iss_rd;
   logic [ADDR_WIDTH-1:0] q_a1;
   logic [ADDR_WIDTH-1:0] q_a2;
   logic                  busy1;
   logic                  busy2;
   logic                  wen3;
   logic [ADDR_WIDTH-1:0] a3;
   logic [DATA_WIDTH-1:0] wd3;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      output iss_valid, iss_is_load, iss_rd,
      output q_a1, q_a2,
      input  alu_ready, ld_ready, busy1, busy2,
      input  wen3, a3, wd3
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      input  iss_valid, iss_is_load, iss_rd,
      input  q_a1, q_a2,
      output alu_ready, ld_ready, busy1, busy2,
      output wen3, a3, wd3
   );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_wb_arbiter
// Drives the register bank write port from two sources: single-cycle ALU
// results and variable-latency load results buffered in a small FIFO.
// Keeps a one-bit-per-register load scoreboard that decode queries.
// Ports:
//   clk            : clock, all updates on posedge
//   rst            : asynchronous active-high reset
//   bus (slave)    : alu/ld handshakes, issue info, scoreboard queries,
//                    registered write port wen3/a3/wd3
//   alu_stall_cnt  : (only with CPU_WB_STATS_EN) saturating count of cycles
//                    with alu_valid & !alu_ready
// Optional feature macro: CPU_WB_STATS_EN
// ----------------------------------------------------------------------------
module cpu_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int LQ_DEPTH   = 4
) (
   input  logic clk,
   input  logic rst,
   cpu_wb_arbiter_if.slave bus
`ifdef CPU_WB_STATS_EN
   ,
   output logic [31:0] alu_stall_cnt
`endif
);

   localparam int PTR_W = $clog2(LQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] lq_rd_q   [LQ_DEPTH];
   logic [ADDR_WIDTH-1:0] lq_rd_d   [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] lq_data_q [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] lq_data_d [LQ_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NREG-1:0]       busy_q, busy_d;
   logic                  wen3_q, wen3_d;
   logic [ADDR_WIDTH-1:0] a3_q, a3_d;
   logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

   logic                  full, empty, push, sel_alu, sel_ld;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   // Readiness depends on the count alone: a pop in the same cycle does not
   // free a slot for a push, which keeps ld_ready off the arbitration path.
   assign full  = (cnt_q == CNT_W'(LQ_DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = bus.ld_valid & ~full;

   always_comb begin
      sel_alu  = 1'b0;
      sel_ld   = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      // A full FIFO takes priority so memory is never blocked indefinitely;
      // otherwise the ALU wins and loads drain only in ALU-idle cycles.
      if (full) begin
         sel_ld = 1'b1;
      end else if (bus.alu_valid) begin
         sel_alu = 1'b1;
      end else if (!empty) begin
         sel_ld = 1'b1;
      end
      if (sel_alu) begin
         sel_rd   = bus.alu_rd;
         sel_data = bus.alu_data;
      end else if (sel_ld) begin
         sel_rd   = lq_rd_q[rd_ptr_q];
         sel_data = lq_data_q[rd_ptr_q];
      end
   end

   always_comb begin
      // x0 requests are consumed but never written.
      wen3_d = (sel_alu | sel_ld) && (sel_rd != '0);
      a3_d   = wen3_d ? sel_rd   : a3_q;
      wd3_d  = wen3_d ? sel_data : wd3_q;

      lq_rd_d   = lq_rd_q;
      lq_data_d = lq_data_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push) begin
         lq_rd_d[wr_ptr_q]   = bus.ld_rd;
         lq_data_d[wr_ptr_q] = bus.ld_data;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (sel_ld) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, sel_ld})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // Clear before set so a same-cycle set on the same register wins.
      busy_d = busy_q;
      if (sel_ld && (sel_rd != '0)) begin
         busy_d[sel_rd] = 1'b0;
      end
      if (bus.iss_valid && bus.iss_is_load && (bus.iss_rd != '0)) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         wen3_q   <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         wen3_q   <= wen3_d;
         a3_q     <= a3_d;
         wd3_q    <= wd3_d;
      end
   end

   // Storage needs no reset: entries are only read when cnt_q says so.
   always_ff @(posedge clk) begin
      lq_rd_q   <= lq_rd_d;
      lq_data_q <= lq_data_d;
   end

   assign bus.alu_ready = ~full;
   assign bus.ld_ready  = ~full;
   assign bus.busy1     = busy_q[bus.q_a1];
   assign bus.busy2     = busy_q[bus.q_a2];
   assign bus.wen3      = wen3_q;
   assign bus.a3        = a3_q;
   assign bus.wd3       = wd3_q;

`ifdef CPU_WB_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.alu_valid && full && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign alu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_wb_arbiter
// Self-checking bench for cpu_wb_arbiter. A cycle model of the FIFO,
// arbitration and scoreboard predicts each write; predicted writes are queued
// and compared when the DUT raises wen3.
// Optional feature macro: CPU_WB_STATS_EN
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_wb_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef CPU_WB_STATS_EN
   logic [31:0] alu_stall_cnt;
`endif

   cpu_wb_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .LQ_DEPTH(DEPTH)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef CPU_WB_STATS_EN
      ,
      .alu_stall_cnt(alu_stall_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   ent_t          m_fifo [$];
   ent_t          exp_q  [$];
   logic [31:0]   m_busy;
   logic          m_wen;
   logic [31:0]   m_stall;
   logic          m_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_fifo.delete();
         exp_q.delete();
         m_busy  = '0;
         m_wen   = 1'b0;
         m_stall = '0;
         m_live  = 1'b1;
      end else if (m_live) begin
         logic full, s_alu, s_ld;
         ent_t sel;
         full  = (m_fifo.size() == DEPTH);
         s_alu = 1'b0;
         s_ld  = 1'b0;
         sel   = '0;
         if (full) s_ld = 1'b1;
         else if (bus.alu_valid) s_alu = 1'b1;
         else if (m_fifo.size() != 0) s_ld = 1'b1;
         if (bus.alu_valid && full) m_stall = m_stall + 1;
         if (s_alu) sel = '{rd: bus.alu_rd, data: bus.alu_data};
         if (s_ld)  sel = m_fifo[0];
         m_wen = (s_alu || s_ld) && (sel.rd != 0);
         if (m_wen) exp_q.push_back(sel);
         if (s_ld && sel.rd != 0) m_busy[sel.rd] = 1'b0;
         if (bus.iss_valid && bus.iss_is_load && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
         if (s_ld) void'(m_fifo.pop_front());
         if (bus.ld_valid && !full) m_fifo.push_back('{rd: bus.ld_rd, data: bus.ld_data});
      end
   end

   // ---------------- checker ----------------
   always @(negedge clk) begin
      if (!rst && m_live) begin
         chk("wen3", bus.wen3, m_wen);
         if (bus.wen3) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("a3", bus.a3, e.rd);
               chk("wd3", bus.wd3, e.data);
            end
            chk("a3_nonzero", (bus.a3 != 0), 1);
         end
         chk("alu_ready", bus.alu_ready, (m_fifo.size() != DEPTH));
         chk("ld_ready", bus.ld_ready, (m_fifo.size() != DEPTH));
         chk("busy1", bus.busy1, m_busy[bus.q_a1]);
         chk("busy2", bus.busy2, m_busy[bus.q_a2]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_rd       = '0;
      bus.ld_data     = '0;
      bus.iss_valid   = 1'b0;
      bus.iss_is_load = 1'b0;
      bus.iss_rd      = '0;
   endtask

   initial begin
      idle();
      bus.q_a1 = '0;
      bus.q_a2 = '0;
      rst = 1'b1;
      #1;
      chk("rst_wen3", bus.wen3, 0);
      chk("rst_a3", bus.a3, 0);
      chk("rst_wd3", bus.wd3, 0);
      chk("rst_ld_ready", bus.ld_ready, 1);
      step(2);
      rst = 1'b0;

      // idle scoreboard scan
      for (int i = 0; i < 32; i++) begin
         bus.q_a1 = AW'(i);
         bus.q_a2 = AW'(31 - i);
         step(1);
      end

      // single ALU write
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5;
      bus.alu_data  = 32'hDEAD_BEEF;
      step(1);
      idle();
      step(2);

      // load to r7: issue, then return
      bus.iss_valid   = 1'b1;
      bus.iss_is_load = 1'b1;
      bus.iss_rd      = 7;
      bus.q_a1        = 7;
      step(1);
      idle();
      step(1);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 7;
      bus.ld_data  = 32'h1234;
      step(1);
      idle();
      step(3);

      // fill FIFO while the ALU keeps requesting
      for (int i = 0; i < 4; i++) begin
         bus.iss_valid   = 1'b1;
         bus.iss_is_load = 1'b1;
         bus.iss_rd      = AW'(8 + i);
         step(1);
      end
      idle();
      bus.q_a1 = 8;
      bus.q_a2 = 11;
      for (int i = 0; i < 10; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_rd    = AW'(16 + i);
         bus.alu_data  = 32'hA000_0000 + i;
         bus.ld_valid  = (i < 4);
         bus.ld_rd     = AW'(8 + i);
         bus.ld_data   = 32'h5000_0000 + i;
         step(1);
      end
      idle();
      step(8);

      // x0 requests
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 0;
      bus.alu_data  = 32'hFFFF_0000;
      step(1);
      idle();
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 0;
      bus.ld_data  = 32'h0000_FFFF;
      step(1);
      idle();
      step(3);

      // reset with three queued loads
      for (int i = 0; i < 3; i++) begin
         bus.alu_valid   = 1'b1;
         bus.alu_rd      = AW'(20 + i);
         bus.alu_data    = 32'hC000_0000 + i;
         bus.iss_valid   = 1'b1;
         bus.iss_is_load = 1'b1;
         bus.iss_rd      = AW'(12 + i);
         bus.ld_valid    = 1'b1;
         bus.ld_rd       = AW'(12 + i);
         bus.ld_data     = 32'h6000_0000 + i;
         step(1);
      end
      idle();
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 23;
      step(1);
      rst = 1'b1;
      idle();
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.q_a1 = AW'(12 + i);
         bus.q_a2 = AW'(14 - i);
         step(1);
      end
      step(4);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         bus.alu_valid   = ($urandom_range(0, 1) == 1);
         bus.alu_rd      = AW'($urandom_range(0, 31));
         bus.alu_data    = $urandom;
         bus.ld_valid    = ($urandom_range(0, 2) != 0);
         bus.ld_rd       = AW'($urandom_range(0, 31));
         bus.ld_data     = $urandom;
         bus.iss_valid   = ($urandom_range(0, 1) == 1);
         bus.iss_is_load = ($urandom_range(0, 1) == 1);
         bus.iss_rd      = AW'($urandom_range(0, 31));
         bus.q_a1        = AW'($urandom_range(0, 31));
         bus.q_a2        = AW'($urandom_range(0, 31));
         step(1);
      end
      idle();
      step(10);

      chk("exp_q_drained", exp_q.size(), 0);
`ifdef CPU_WB_STATS_EN
      chk("alu_stall_cnt", alu_stall_cnt, m_stall);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Writeback-side driver of the CPU register bank write port (a3/wen3/wd3).
- Merges two result sources:
  - ALU results, single-cycle.
  - Load results returning from data memory, variable latency, buffered in a small FIFO.
- Keeps a load scoreboard (one busy bit per register). Decode queries it to stall on pending load destinations.

Parameters:
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers, x0 hardwired zero.
- DATA_WIDTH, 32, register data width.
- LQ_DEPTH, 4, load-result FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result request.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result from memory.
- ld_ready  out  1  load FIFO can accept.
- ld_rd  in  ADDR_WIDTH  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- iss_valid  in  1  decode issues an instruction.
- iss_is_load  in  1  issued instruction is a load.
- iss_rd  in  ADDR_WIDTH  issued instruction destination.
- q_a1  in  ADDR_WIDTH  scoreboard query address 1.
- q_a2  in  ADDR_WIDTH  scoreboard query address 2.
- busy1  out  1  q_a1 has a load pending.
- busy2  out  1  q_a2 has a load pending.
- wen3  out  1  register bank write enable.
- a3  out  ADDR_WIDTH  register bank write address.
- wd3  out  DATA_WIDTH  register bank write data.

Behaviour:
- Reset (rst high, async):
  - wen3=0, a3=0, wd3=0.
  - FIFO emptied (pointers and count = 0).
  - All busy bits cleared.
  - Mid-operation reset discards queued load results with no partial write.
- Load FIFO:
  - ld_ready = !full; combinational from count only, no same-cycle pop credit.
  - Push on ld_valid & ld_ready.
  - Pointers wrap modulo LQ_DEPTH.
  - count width is clog2(LQ_DEPTH)+1.
  - Simultaneous push and pop leaves count unchanged.
- Arbitration (one write slot per cycle):
  - FIFO full and nonempty → pop FIFO head; alu_ready=0.
  - Else, alu_valid → alu_ready=1; ALU wins; FIFO holds.
  - Else, FIFO nonempty → pop head.
  - alu_ready = !full, combinational.
- Output register:
  - The selected request is registered into wen3/a3/wd3 at the next posedge.
  - ALU accepted in cycle N → wen3 high in N+1.
  - Load pushed in cycle N → earliest wen3 in N+2.
  - With no selection, wen3=0; a3/wd3 hold their previous values.
- x0 rule:
  - A selected request with rd==0 is consumed (handshake completes, FIFO pops) but produces wen3=0.
  - wen3 is never asserted with a3==0.
- Scoreboard:
  - Set: busy[iss_rd] on iss_valid & iss_is_load & iss_rd!=0.
  - Clear: busy[rd] when a FIFO pop with rd!=0 is selected.
  - Clear takes effect at the same edge that registers wen3.
  - Same register set and cleared in one cycle → set wins.
  - busy[0] is constantly 0.
  - busy1/busy2 are combinational reads of the busy vector.
  - Decode must stall any instruction whose sources or destination are busy. This block performs no WAW check.
- Ordering:
  - Load results commit in arrival order.
  - ALU results commit in acceptance order.
  - No ordering is defined between the two streams.

Optional Feature:
- Macro CPU_WB_STATS_EN.
- When defined, adds output port alu_stall_cnt (32 bits):
  - Counts cycles with alu_valid & !alu_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → wen3=0, ld_ready=1, alu_ready=1, busy1=busy2=0 for all query addresses.
- alu_valid, alu_rd=5, alu_data=0xDEADBEEF at cycle N → wen3=1, a3=5, wd3=0xDEADBEEF in N+1 only.
- Issue load to rd=7 → busy1=1 for q_a1=7. ld_valid, rd=7, data=0x1234 with ALU idle → wen3/a3=7/wd3=0x1234 two cycles later; busy1=0 after that edge.
- Hold alu_valid every cycle while pushing 4 loads:
  - ld_ready=0 after the 4th push.
  - alu_ready=0 while full.
  - Loads drain in order.
  - Stats build: alu_stall_cnt equals the stall cycles.
- ALU write with rd=0 and load with rd=0 → both handshakes complete, wen3 stays 0.
- Fill FIFO with 3 entries, assert rst mid-stream → FIFO empty, busy cleared, no wen3 after rst deasserts.
